// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, special register addresses
// and the soft-clear FSM state type.
package cpu_pkg;
    localparam int unsigned CPU_WIDTH  = 32;
    localparam int unsigned CPU_ADDR_W = 5;

    localparam logic [CPU_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;
endpackage

// File: rtl/reg_file_rdport.sv
// One register-file read port: zero-register masking, then write bypass,
// then the stored value.
module reg_file_rdport
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH    = CPU_WIDTH,
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] sel_i,
    input  logic [WIDTH-1:0]  stored_i,
    input  logic              wr_commit_i,
    input  logic [ADDR_W-1:0] wr_sel_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o
);
    logic is_zero;

    assign is_zero = (ZERO_REG != 0) && (sel_i == ADDR_W'(REG_ZERO));

    always_comb begin
        rd_data_o = stored_i;
        if (is_zero) begin
            rd_data_o = '0;
        end else if (wr_commit_i && (wr_sel_i == sel_i)) begin
            rd_data_o = wr_data_i;
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, optional zero register,
// a one-entry-per-cycle soft-clear sequencer and debug taps on r1..rNDBG.
module reg_file_mp
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH    = CPU_WIDTH,
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned NDBG     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NREAD*ADDR_W-1:0] rd_sel,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_sel,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic [NDBG*WIDTH-1:0]   dbg
);
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    clr_state_t        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_drop_zero;
    logic              wr_commit;

    assign wr_drop_zero = (ZERO_REG != 0) && (wr_sel == ADDR_W'(REG_ZERO));
    assign wr_commit    = wr_en && en && !busy_q && !wr_drop_zero;

    assign clr_busy = busy_q;
    assign clr_done = done_q;

    // Clear sequencer; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    done_q <= 1'b0;
                    if (clr_req && en) begin
                        state_q <= CLR_RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    done_q <= 1'b0;
                    if (en) begin
                        idx_q <= idx_q + ADDR_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_q <= CLR_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the clear engine and the write port never act in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if ((state_q == CLR_RUN) && en) begin
            mem_q[idx_q] <= '0;
        end else if (wr_commit) begin
            mem_q[wr_sel] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        assign sel = rd_sel[k*ADDR_W +: ADDR_W];

        reg_file_rdport #(
            .WIDTH   (WIDTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rdport (
            .sel_i      (sel),
            .stored_i   (mem_q[sel]),
            .wr_commit_i(wr_commit),
            .wr_sel_i   (wr_sel),
            .wr_data_i  (wr_data),
            .rd_data_o  (rd_data[k*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < NDBG; j++) begin : g_dbg
        assign dbg[j*WIDTH +: WIDTH] = mem_q[j+1];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: the driver predicts each cycle's outputs
// from an array model and queues them; a negedge monitor pops and compares.
module tb_reg_file_mp;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned ND = 4;
    localparam int unsigned DP = 32;

    typedef struct packed {
        logic [NR*W-1:0] rd;
        logic [ND*W-1:0] dbg;
        logic            busy;
        logic            done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, en, wr_en, clr_req;
    logic [NR*AW-1:0] rd_sel;
    logic [AW-1:0]    wr_sel;
    logic [W-1:0]     wr_data;
    logic [NR*W-1:0]  rd_data;
    logic             clr_busy, clr_done;
    logic [ND*W-1:0]  dbg;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic [W-1:0] m_mem [DP];
    bit           m_busy, m_done;
    int           m_idx;

    reg_file_mp #(.WIDTH(W), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .NDBG(ND)) dut (
        .clk(clk), .reset(reset), .en(en), .rd_sel(rd_sel), .rd_data(rd_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done), .dbg(dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_data", 128'(rd_data), 128'(e.rd));
            check("dbg", 128'(dbg), 128'(e.dbg));
            check("clr_busy", 128'(clr_busy), 128'(e.busy));
            check("clr_done", 128'(clr_done), 128'(e.done));
        end
    end

    // One clock cycle: predict outputs for the current inputs, then advance the model.
    task automatic step();
        exp_t e;
        bit   commit;
        int   s;
        commit = wr_en && en && !m_busy && (wr_sel != 0);
        for (int k = 0; k < int'(NR); k++) begin
            s = int'(rd_sel[k*AW +: AW]);
            if (s == 0) e.rd[k*W +: W] = '0;
            else if (commit && int'(wr_sel) == s) e.rd[k*W +: W] = wr_data;
            else e.rd[k*W +: W] = m_mem[s];
        end
        for (int j = 0; j < int'(ND); j++) e.dbg[j*W +: W] = m_mem[j+1];
        e.busy = m_busy;
        e.done = m_done;
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < int'(DP); i++) m_mem[i] = '0;
            m_busy = 0; m_done = 0; m_idx = 0;
        end else begin
            bit nd = 0;
            if (m_busy) begin
                if (en) begin
                    m_mem[m_idx] = '0;
                    if (m_idx == int'(DP) - 1) begin
                        m_busy = 0;
                        nd = 1;
                    end
                    m_idx++;
                end
            end else begin
                if (commit) m_mem[wr_sel] = wr_data;
                if (clr_req && en) begin
                    m_busy = 1;
                    m_idx = 0;
                end
            end
            m_done = nd;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; en = 1; wr_en = 0; clr_req = 0; wr_sel = '0; wr_data = '0;
    endtask

    task automatic set_rd(input int s0, input int s1);
        rd_sel = {AW'(s1), AW'(s0)};
    endtask

    task automatic write(input int sel, input logic [W-1:0] data);
        wr_en = 1; wr_sel = AW'(sel); wr_data = data;
        step();
        wr_en = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < int'(DP); i++) write(i, W'(i + 1));
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(DP); i += 2) begin
            set_rd(i, i + 1);
            step();
        end
    endtask

    initial begin
        int cnt;
        idle_inputs();
        rd_sel = '0;
        reset = 1;
        for (int i = 0; i < int'(DP); i++) m_mem[i] = '0;
        m_busy = 0; m_done = 0; m_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state, then write/readback.
        set_rd(5, 31);
        step();
        write(5, 32'hDEADBEEF);
        write(31, 32'h12345678);
        set_rd(5, 31);
        step();
        set_rd(2, 4);
        step();

        // Bypass on r3 (debug tap 2) and the zero register.
        set_rd(3, 3);
        write(3, 32'hA5A5A5A5);
        step();
        set_rd(0, 0);
        write(0, 32'hFFFFFFFF);
        step();

        // Soft clear with a dropped write to r7.
        fill();
        set_rd(10, 20);
        clr_req = 1;
        step();
        clr_req = 0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            if (cnt == 5 || cnt == 6) begin
                wr_en = 1; wr_sel = AW'(7); wr_data = 32'h77777777;
            end else wr_en = 0;
            if (cnt == 12) set_rd(7, 20);
            cnt++;
            step();
        end
        wr_en = 0;
        check("clr_busy_len", 128'(cnt), 128'(32));
        set_rd(10, 20);
        step();
        read_all();

        // clr_req coincident with a write to r2.
        fill();
        set_rd(2, 1);
        clr_req = 1;
        write(2, 32'h00005555);
        clr_req = 0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin cnt++; step(); end
        step();
        read_all();

        // Stall mid-clear and an ignored second request.
        fill();
        set_rd(10, 20);
        clr_req = 1;
        step();
        clr_req = 0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            en = !(cnt >= 10 && cnt < 13);
            clr_req = (cnt == 15);
            cnt++;
            step();
        end
        en = 1; clr_req = 0;
        check("clr_busy_stall_len", 128'(cnt), 128'(35));
        step();

        // Reset when the clear index reaches 12.
        fill();
        set_rd(11, 13);
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (12) step();
        reset = 1;
        step();
        reset = 0;
        check("clr_busy_after_reset", 128'(clr_busy), 128'(0));
        read_all();
        set_rd(1, 1);
        write(1, 32'hCAFEF00D);
        step();

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 299) == 0);
            en      = ($urandom_range(0, 7) != 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_sel  = AW'($urandom_range(0, DP - 1));
            wr_data = $urandom;
            clr_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) set_rd(int'(wr_sel), $urandom_range(0, DP - 1));
            else set_rd($urandom_range(0, DP - 1), $urandom_range(0, DP - 1));
            step();
        end
        idle_inputs();
        step();

        @(negedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port CPU register file, the next generation of the datapath register bank. It provides NREAD combinational read ports with same-cycle write-to-read bypass and one write port gated by `en`. A hardwired zero register is optional. A sequenced soft-clear engine zeroes the array one entry per cycle without a full reset, and the first NDBG registers are exposed as debug taps for the board display.

## Interface
- `WIDTH`, 32: data width of each register.
- `ADDR_W`, 5: select width; DEPTH = 2**ADDR_W entries.
- `NREAD`, 2: number of read ports (1..4).
- `ZERO_REG`, 1: 1 means entry 0 always reads 0 and ignores writes.
- `NDBG`, 4: number of debug taps, giving registers 1..NDBG (NDBG < DEPTH).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  stall control; when low, writes and clear progress are frozen.
- `rd_sel`  in  NREAD*ADDR_W  read selects; port k is bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NREAD*WIDTH  read data; port k is bits [k*WIDTH +: WIDTH].
- `wr_en`  in  1  write request.
- `wr_sel`  in  ADDR_W  write select.
- `wr_data`  in  WIDTH  write data.
- `clr_req`  in  1  single-cycle soft-clear request.
- `clr_busy`  out  1  high while the clear sequence is running.
- `clr_done`  out  1  one-cycle pulse on the cycle the last entry is cleared.
- `dbg`  out  NDBG*WIDTH  contents of registers 1..NDBG; tap j is register j+1.

## Operation
- Write commit condition: `wr_en && en && !clr_busy`. The write is dropped if ZERO_REG=1 and `wr_sel`==0.
  - A committed write updates the register on the next rising edge.
  - A write that does not meet the condition is dropped silently, with no queueing.
- Read port k, in priority order:
  - If ZERO_REG=1 and sel==0, the port returns 0.
  - Otherwise, if a write commits this cycle and `wr_sel`==sel, the port returns `wr_data` (bypass).
  - Otherwise, the port returns the stored value.
- All ports resolve independently, so identical selects on several ports are legal.
- `dbg` shows the stored values only, with no bypass.
- Clear FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when `clr_req && en`. The index counter loads 0.
  - In CLEAR with `en`=1, entry[idx] is set to 0 and idx increments. When idx==DEPTH-1, that entry is cleared, `clr_done` pulses and the FSM returns to IDLE.
  - In CLEAR with `en`=0, the FSM holds its state and idx.
  - `clr_req` during CLEAR is ignored and does not restart the sequence.
- Reads during CLEAR return the current array: entries below idx read 0 and the rest keep old values. Bypass is inactive during CLEAR because no writes commit.
- `clr_req` and a write in the same IDLE cycle: the write commits on that edge. The clear then starts on the following cycle and zeroes that entry.
- Reset clears all entries to 0 in one edge. It also puts the FSM in IDLE, sets idx to 0, and drives `clr_busy`=0 and `clr_done`=0. Reset overrides a write, a request or a clear in progress.

## Timing
- Read latency is 0 cycles (combinational from `rd_sel`, `wr_*` and the array).
- Write latency is 1 cycle; the value is visible from storage on the cycle after the edge.
- `clr_busy` rises on the edge that samples `clr_req`.
  - With `en` held high, it stays high for exactly DEPTH cycles and falls on the edge that clears entry DEPTH-1.
  - Each `en`=0 cycle during CLEAR extends the sequence by one cycle.
- `clr_done` is registered and is high in the first cycle after the sequence ends, coincident with `clr_busy`=0.
- A write can commit in the first cycle after `clr_busy` falls.
- Output values after reset:
  - `rd_data` = 0 for any select while no write is active.
  - `dbg` = 0.
  - `clr_busy` = 0 and `clr_done` = 0.

## Structure
- Shared package `cpu_pkg`:
  - `typedef enum {CLR_IDLE, CLR_RUN} clr_state_t`.
  - Default WIDTH and ADDR_W constants, kept common with the decoder and ALU.
  - `REG_ZERO` address constant.
- Sub-module `reg_file_rdport`: one instance per read port (generate loop), covering zero-register masking and the bypass mux.
- The top level owns the array, the write gating, the clear FSM/counter and the debug taps.

## Test plan
- Write/readback:
  - Reset, write 0xDEADBEEF to r5 and 0x12345678 to r31.
  - Next cycle read r5 and r31 on ports 0 and 1 -> the same values, and `dbg` = 0 except where the select is in 1..4.
- Bypass: write 0xA5A5A5A5 to r3 with `rd_sel` port0=3 in the same cycle.
  - Port0 -> 0xA5A5A5A5 that cycle.
  - `dbg` tap 2 updates only on the next cycle.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0, then read r0 -> 0, and the bypass also returns 0.
- Soft clear:
  - Fill r0..r31 with their index+1, pulse `clr_req`.
  - `clr_busy` is high for 32 cycles; mid-sequence, r10 reads 0 after cycle 11 and r20 still reads 21.
  - `clr_done` pulses once and all entries then read 0.
  - A write to r7 during the clear is dropped.
- Stall and simultaneous events:
  - `clr_req` in the same cycle as a write to r2: r2 ends at 0.
  - Drop `en` for 3 cycles mid-clear: `clr_busy` lasts 35 cycles, and a second `clr_req` mid-sequence is ignored.
- Reset mid-clear: assert `reset` at idx=12 -> next cycle `clr_busy`=0 with all entries 0. A subsequent write to r1 commits normally.
